mips_data_mem_sync: RTL and testbench
=====================================

# mips_data_mem_sync

Parametrised, clocked successor to the single-cycle MIPS data memory. It adds:
- a synchronous word array with big-endian byte/half/word access;
- sign- or zero-extended loads with one-cycle registered read latency;
- a post-reset clear sequence that zeroes every word;
- an error flag for illegal requests.

It sits between the datapath's ALU result / rt operand and the write-back mux.

## Interface
- ADDR_WIDTH, 32, byte-address width of `mem_address`
- DEPTH_WORDS, 256, number of 32-bit words; power of two, at least 4
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- mem_address  input  ADDR_WIDTH  byte address
- write_data  input  32  store data, right-justified for byte/half stores
- mem_read  input  1  load request
- mem_write  input  1  store request
- mem_size  input  2  00 byte, 01 half, 10 word, 11 reserved (flagged as error)
- mem_unsigned  input  1  1 zero-extends byte/half loads, 0 sign-extends
- read_data  output  32  registered load result
- read_valid  output  1  one-cycle pulse when `read_data` is updated
- mem_ready  output  1  high when requests are accepted
- mem_error  output  1  one-cycle pulse for a rejected request

## Operation
- **Word index and byte lanes**
  - Word index = `mem_address[log2(DEPTH_WORDS)+1:2]`.
  - Big-endian: byte offset 0 maps to bits 31:24, offset 3 maps to bits 7:0.
- **States**
  - CLEAR: `clr_cnt` steps from 0 to DEPTH_WORDS-1 and writes 0 to word `clr_cnt` each cycle. `mem_ready` is 0. Moves to RUN after writing word DEPTH_WORDS-1.
  - RUN: `mem_ready` is 1. Stays in RUN until reset.
- **Request acceptance**
  - A request is accepted in RUN when exactly one of `mem_read`/`mem_write` is high.
  - If neither is high, nothing happens.
  - Any request presented while `mem_ready`=0 is ignored with no error.
- **Error conditions.** `mem_error` pulses the next cycle and the access is suppressed (no write, no `read_valid`) when, in RUN:
  - `mem_read` and `mem_write` are both high, or
  - `mem_size`=11, or
  - address bits above the word index are non-zero (out of range), or
  - an alignment fault occurs (see Configuration).
- **Store**
  - Byte: writes `write_data[7:0]` into the addressed lane.
  - Half: writes `write_data[15:0]` into lanes {2·`addr[1]`, 2·`addr[1]`+1}.
  - Word: writes all 4 lanes.
  - Lanes not written keep their value.
- **Load**
  - Extracts the addressed byte/half, extends it per `mem_unsigned`, and registers the result into `read_data`.
  - `read_data` holds its value until the next successful load.

## Timing
- **Reset values:** `read_data`=0, `read_valid`=0, `mem_ready`=0, `mem_error`=0, state=CLEAR, `clr_cnt`=0.
- **Clear duration:** with `reset` deasserted before edge 0, CLEAR occupies edges 0..DEPTH_WORDS-1. `mem_ready` reads 1 after edge DEPTH_WORDS-1.
- **Load latency:** a load accepted at edge N gives `read_data`/`read_valid` after edge N; `read_valid` drops after edge N+1 unless another load is accepted.
- **Store:** a store accepted at edge N updates the array at edge N. A load of the same word at edge N+1 returns the new data.
- **Back-to-back:** one request per cycle at full throughput, with no bubbles.
- **Error pulse:** `mem_error` rises after the edge that saw the bad request and lasts one cycle per bad request.
- **Reset mid-operation:**
  - Reset during CLEAR restarts `clr_cnt` at 0.
  - Reset during RUN aborts the current request: no write occurs, `read_valid` is 0, and the array is re-zeroed through CLEAR.

## Configuration
- **MIPS_DMEM_ALIGN_CHECK_EN defined:**
  - A half access with `addr[0]`=1, or a word access with `addr[1:0]`≠0, is an alignment fault.
  - The fault pulses `mem_error` and suppresses the access.
- **MIPS_DMEM_ALIGN_CHECK_EN undefined:**
  - No alignment faults are raised.
  - Word accesses ignore `addr[1:0]`; half accesses ignore `addr[0]`.

## Test plan
- **Reset clear:** reset 2 cycles, then idle → `mem_ready`=0 for exactly DEPTH_WORDS cycles, then 1. A word load at 0x14 then returns 0x00000000.
- **Word round trip:** store word 0xFDFFFFFF at 0x14, load word at 0x14 next cycle → `read_data`=0xFDFFFFFF with `read_valid` one cycle later. Loads at 0x14–0x17 as bytes return 0xFFFFFFFD, 0xFFFFFFFF, 0xFFFFFFFF, 0xFFFFFFFF (signed).
- **Byte/half lanes:** word 0x11223344 at 0x20, store byte 0xAA at 0x21 → word load gives 0x11AA3344. Unsigned half load at 0x22 → 0x00003344; signed byte load at 0x21 → 0xFFFFFFAA.
- **Conflict:**
  - `mem_read`=`mem_write`=1 at 0x14 with data 0x12345678 → `mem_error` pulse, no `read_valid`, word unchanged.
  - Both low → no outputs change.
- **Range/size errors:**
  - Word store at byte address 4·DEPTH_WORDS → `mem_error`, and word 0 is unchanged.
  - `mem_size`=11 → `mem_error`.
- **Alignment:** word load at 0x15.
  - With MIPS_DMEM_ALIGN_CHECK_EN: `mem_error`, `read_valid`=0.
  - Without: returns the word at 0x14.

Source files
------------

// File: rtl/mips_data_mem_sync.sv
// rtl/mips_data_mem_sync.sv - clocked MIPS data memory with big-endian byte/half/word access
//
// Purpose: synchronous word array between the ALU result / rt operand and the
// write-back mux. After reset a CLEAR sequence zeroes every word, then the
// memory accepts one load or store per cycle. Loads are registered (one-cycle
// latency) and sign- or zero-extended. Illegal requests pulse mem_error.
//
// Optional feature macro: MIPS_DMEM_ALIGN_CHECK_EN (misaligned half/word
// accesses become errors; otherwise the low address bits are ignored).
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-high reset
//   mem_address  byte address (ADDR_WIDTH bits)
//   write_data   store data, right-justified for byte/half stores
//   mem_read     load request
//   mem_write    store request
//   mem_size     00 byte, 01 half, 10 word, 11 reserved (error)
//   mem_unsigned 1 zero-extends byte/half loads, 0 sign-extends
//   read_data    registered load result, held until the next successful load
//   read_valid   one-cycle pulse when read_data is updated
//   mem_ready    high when requests are accepted
//   mem_error    one-cycle pulse for a rejected request

module mips_data_mem_sync #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH_WORDS = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] mem_address,
  input  logic [31:0]           write_data,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [1:0]            mem_size,
  input  logic                  mem_unsigned,
  output logic [31:0]           read_data,
  output logic                  read_valid,
  output logic                  mem_ready,
  output logic                  mem_error
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH_WORDS - 1);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] clr_cnt, clr_cnt_d;

  logic [31:0] mem [0:DEPTH_WORDS-1];

  logic [IDX_W-1:0] word_idx;
  logic             out_of_range;
  logic             align_fault;
  logic             req;
  logic             bad;
  logic             run;
  logic             do_read;
  logic             do_write;
  logic             reject;
  logic [4:0]       sh;
  logic [31:0]      lane_mask;
  logic [31:0]      merged;
  logic [31:0]      rshift;
  logic [31:0]      load_val;

  assign word_idx     = mem_address[IDX_W+1:2];
  // Anything above the word index selects a word that does not exist.
  assign out_of_range = |(mem_address >> (IDX_W + 2));

`ifdef MIPS_DMEM_ALIGN_CHECK_EN
  assign align_fault = ((mem_size == 2'b01) && mem_address[0]) ||
                       ((mem_size == 2'b10) && (mem_address[1:0] != 2'b00));
`else
  assign align_fault = 1'b0;
`endif

  assign run      = (state_q == RUN);
  assign req      = mem_read | mem_write;
  assign bad      = (mem_read & mem_write) | (mem_size == 2'b11) | out_of_range | align_fault;
  assign do_read  = run & mem_read & ~mem_write & ~bad;
  assign do_write = run & mem_write & ~mem_read & ~bad;
  assign reject   = run & req & bad;

  assign mem_ready = run;

  // Big-endian lanes: offset 0 lives in bits 31:24, so the shift that moves
  // the addressed byte/half down to bit 0 is (3-offset)*8 or (1-half)*16.
  // Word accesses (and halves' low bit) ignore the address bits here; when
  // the alignment check is enabled those cases are already rejected.
  always_comb begin
    sh        = 5'd0;
    lane_mask = 32'hFFFF_FFFF;
    case (mem_size)
      2'b00: begin
        sh        = {~mem_address[1:0], 3'b000};
        lane_mask = 32'h0000_00FF << sh;
      end
      2'b01: begin
        sh        = {~mem_address[1], 4'b0000};
        lane_mask = 32'h0000_FFFF << sh;
      end
      default: begin
        sh        = 5'd0;
        lane_mask = 32'hFFFF_FFFF;
      end
    endcase
  end

  assign merged = (mem[word_idx] & ~lane_mask) | ((write_data << sh) & lane_mask);
  assign rshift = mem[word_idx] >> sh;

  always_comb begin
    load_val = rshift;
    case (mem_size)
      2'b00:   load_val = mem_unsigned ? {24'h0, rshift[7:0]}
                                       : {{24{rshift[7]}}, rshift[7:0]};
      2'b01:   load_val = mem_unsigned ? {16'h0, rshift[15:0]}
                                       : {{16{rshift[15]}}, rshift[15:0]};
      default: load_val = rshift;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state_q <= state_d;
      clr_cnt <= clr_cnt_d;
    end
  end

  // Next state: walk every word once, then run until reset.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt;
    case (state_q)
      CLEAR: begin
        clr_cnt_d = clr_cnt + 1'b1;
        if (clr_cnt == LAST_IDX) begin
          state_d = RUN;
        end
      end
      RUN:     state_d = RUN;
      default: state_d = CLEAR;
    endcase
  end

  // Array: zero-fill during CLEAR, lane-merged store during RUN. Reset
  // blocks both, so a request coinciding with reset never lands.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == CLEAR) begin
        mem[clr_cnt] <= '0;
      end else if (do_write) begin
        mem[word_idx] <= merged;
      end
    end
  end

  // Registered load result and status pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      read_data  <= '0;
      read_valid <= 1'b0;
      mem_error  <= 1'b0;
    end else begin
      read_valid <= do_read;
      mem_error  <= reject;
      if (do_read) begin
        read_data <= load_val;
      end
    end
  end

endmodule

// File: tb/tb_mips_data_mem_sync.sv
// tb/tb_mips_data_mem_sync.sv - self-checking bench for mips_data_mem_sync

module tb_mips_data_mem_sync;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] mem_address;
  logic [31:0] write_data;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_size;
  logic        mem_unsigned;
  logic [31:0] read_data;
  logic        read_valid;
  logic        mem_ready;
  logic        mem_error;

  mips_data_mem_sync #(.ADDR_WIDTH(32), .DEPTH_WORDS(DEPTH)) dut (
    .clk(clk),
    .reset(reset),
    .mem_address(mem_address),
    .write_data(write_data),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .mem_size(mem_size),
    .mem_unsigned(mem_unsigned),
    .read_data(read_data),
    .read_valid(read_valid),
    .mem_ready(mem_ready),
    .mem_error(mem_error)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: flat big-endian byte array plus the held load result.
  logic [7:0]  mb [0:4*DEPTH-1];
  logic [31:0] m_held;

`ifdef MIPS_DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  typedef struct {
    logic        rd;
    logic        wr;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] a;
    logic [31:0] d;
    logic        e;
    logic        v;
    logic [31:0] r;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rd, logic wr, logic [1:0] sz, logic uns,
                              logic [31:0] a, logic [31:0] d,
                              logic e, logic v, logic [31:0] r);
    vec_t x;
    x.rd = rd; x.wr = wr; x.sz = sz; x.uns = uns; x.a = a; x.d = d;
    x.e = e; x.v = v; x.r = r;
    return x;
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4*DEPTH; i++) mb[i] = 8'h00;
    m_held = 32'h0;
  endtask

  task automatic model_step(input logic rd, input logic wr, input logic [1:0] sz,
                            input logic uns, input logic [31:0] a, input logic [31:0] d,
                            output logic e, output logic v, output logic [31:0] r);
    int          n;
    int          base;
    logic [31:0] val;
    logic        bad;
    e = 1'b0;
    v = 1'b0;
    bad = (rd && wr) || (sz == 2'b11) || (a >= 32'(4*DEPTH)) ||
          (ALIGN && ((sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00)));
    if (rd || wr) begin
      if (bad) begin
        e = 1'b1;
      end else begin
        n    = 1 << sz;
        base = int'(a) & ~(n - 1);
        if (wr) begin
          for (int i = 0; i < n; i++) mb[base+i] = d[8*(n-1-i) +: 8];
        end else begin
          val = 32'h0;
          for (int i = 0; i < n; i++) val = {val[23:0], mb[base+i]};
          if (!uns && n == 1) val = {{24{val[7]}}, val[7:0]};
          if (!uns && n == 2) val = {{16{val[15]}}, val[15:0]};
          m_held = val;
          v = 1'b1;
        end
      end
    end
    r = m_held;
  endtask

  task automatic tick(input logic rd, input logic wr, input logic [1:0] sz,
                      input logic uns, input logic [31:0] a, input logic [31:0] d);
    mem_read = rd; mem_write = wr; mem_size = sz; mem_unsigned = uns;
    mem_address = a; write_data = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    tick(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic check_outs(input string tag, input logic e, input logic v, input logic [31:0] r);
    check({tag, " mem_error"}, {31'h0, mem_error}, {31'h0, e});
    check({tag, " read_valid"}, {31'h0, read_valid}, {31'h0, v});
    check({tag, " read_data"}, read_data, r);
  endtask

  // Counts idle cycles until mem_ready rises (bounded) and checks the length.
  task automatic wait_clear(input string tag);
    int n = 0;
    while (mem_ready !== 1'b1 && n < 2000) begin
      idle();
      n++;
    end
    check(tag, n, DEPTH);
    model_clear();
  endtask

  // Model-checked request: drive, tick, compare DUT against the model.
  task automatic step_chk(input string tag, input logic rd, input logic wr, input logic [1:0] sz,
                          input logic uns, input logic [31:0] a, input logic [31:0] d);
    logic        e, v;
    logic [31:0] r;
    model_step(rd, wr, sz, uns, a, d, e, v, r);
    tick(rd, wr, sz, uns, a, d);
    check_outs(tag, e, v, r);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic        e, v;
    logic [31:0] r;
    int          sel;
    logic        rd, wr;
    logic [31:0] a;

    mem_read = 0; mem_write = 0; mem_size = 0; mem_unsigned = 0;
    mem_address = 0; write_data = 0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outs("reset", 1'b0, 1'b0, 32'h0);
    check("reset mem_ready", {31'h0, mem_ready}, 32'h0);
    reset = 1'b0;
    wait_clear("clear length");

    // Directed vectors
    tbl.push_back(mk(1, 0, 2'b10, 0, 32'h14, 32'h0,          0, 1, 32'h0000_0000));
    tbl.push_back(mk(0, 1, 2'b10, 0, 32'h14, 32'hFDFF_FFFF,  0, 0, 32'h0000_0000));
    tbl.push_back(mk(1, 0, 2'b10, 0, 32'h14, 32'h0,          0, 1, 32'hFDFF_FFFF));
    tbl.push_back(mk(1, 0, 2'b00, 0, 32'h14, 32'h0,          0, 1, 32'hFFFF_FFFD));
    tbl.push_back(mk(1, 0, 2'b00, 0, 32'h15, 32'h0,          0, 1, 32'hFFFF_FFFF));
    tbl.push_back(mk(1, 0, 2'b00, 0, 32'h16, 32'h0,          0, 1, 32'hFFFF_FFFF));
    tbl.push_back(mk(1, 0, 2'b00, 0, 32'h17, 32'h0,          0, 1, 32'hFFFF_FFFF));
    tbl.push_back(mk(0, 1, 2'b10, 0, 32'h20, 32'h1122_3344,  0, 0, 32'hFFFF_FFFF));
    tbl.push_back(mk(0, 1, 2'b00, 0, 32'h21, 32'h0000_00AA,  0, 0, 32'hFFFF_FFFF));
    tbl.push_back(mk(1, 0, 2'b10, 0, 32'h20, 32'h0,          0, 1, 32'h11AA_3344));
    tbl.push_back(mk(1, 0, 2'b01, 1, 32'h22, 32'h0,          0, 1, 32'h0000_3344));
    tbl.push_back(mk(1, 0, 2'b00, 0, 32'h21, 32'h0,          0, 1, 32'hFFFF_FFAA));
    tbl.push_back(mk(1, 1, 2'b10, 0, 32'h14, 32'h1234_5678,  1, 0, 32'hFFFF_FFAA));
    tbl.push_back(mk(0, 0, 2'b10, 0, 32'h14, 32'h1234_5678,  0, 0, 32'hFFFF_FFAA));
    tbl.push_back(mk(1, 0, 2'b10, 0, 32'h14, 32'h0,          0, 1, 32'hFDFF_FFFF));
    tbl.push_back(mk(0, 1, 2'b10, 0, 32'h400, 32'hDEAD_BEEF, 1, 0, 32'hFDFF_FFFF));
    tbl.push_back(mk(1, 0, 2'b10, 0, 32'h0,  32'h0,          0, 1, 32'h0000_0000));
    tbl.push_back(mk(1, 0, 2'b11, 0, 32'h0,  32'h0,          1, 0, 32'h0000_0000));
`ifdef MIPS_DMEM_ALIGN_CHECK_EN
    tbl.push_back(mk(1, 0, 2'b10, 0, 32'h15, 32'h0,          1, 0, 32'h0000_0000));
`else
    tbl.push_back(mk(1, 0, 2'b10, 0, 32'h15, 32'h0,          0, 1, 32'hFDFF_FFFF));
`endif
    tbl.push_back(mk(0, 0, 2'b00, 0, 32'h0,  32'h0,          0, 0, tbl[tbl.size()-1].r));

    for (int i = 0; i < tbl.size(); i++) begin
      model_step(tbl[i].rd, tbl[i].wr, tbl[i].sz, tbl[i].uns, tbl[i].a, tbl[i].d, e, v, r);
      tick(tbl[i].rd, tbl[i].wr, tbl[i].sz, tbl[i].uns, tbl[i].a, tbl[i].d);
      check_outs($sformatf("vec%0d", i), tbl[i].e, tbl[i].v, tbl[i].r);
    end

    // Reset during RUN: the coincident load is aborted and the array re-zeroed.
    reset = 1'b1;
    tick(1'b1, 1'b0, 2'b10, 1'b0, 32'h14, 32'h0);
    check_outs("run reset", 1'b0, 1'b0, 32'h0);
    check("run reset mem_ready", {31'h0, mem_ready}, 32'h0);
    reset = 1'b0;
    wait_clear("clear after run reset");
    step_chk("rezero 0x14", 1'b1, 1'b0, 2'b10, 1'b0, 32'h14, 32'h0);

    // Reset during CLEAR restarts the full sweep.
    step_chk("store 0x8", 1'b0, 1'b1, 2'b10, 1'b0, 32'h8, 32'h55AA_55AA);
    reset = 1'b1;
    idle();
    reset = 1'b0;
    repeat (50) idle();
    check("mid clear mem_ready", {31'h0, mem_ready}, 32'h0);
    reset = 1'b1;
    idle();
    reset = 1'b0;
    wait_clear("clear restart length");
    step_chk("rezero 0x8", 1'b1, 1'b0, 2'b10, 1'b0, 32'h8, 32'h0);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      sel = $urandom_range(0, 7);
      rd  = (sel == 1) || (sel >= 2 && sel <= 4);
      wr  = (sel == 1) || (sel >= 5);
      a   = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 63));
      step_chk($sformatf("rand%0d", i), rd, wr, 2'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), a, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
